// File: rtl/port_arbiter.sv
// Round-robin output-port arbiter with packet locking and credit-based flow control.
// One flit per grant is registered onto out_flit/out_valid one cycle after the grant.
module port_arbiter #(
    parameter int M_IN     = 6,
    parameter int FLIT_W   = 85,
    parameter int TAIL_POS = 80,
    parameter int CREDITS  = 4,
    parameter int CW       = $clog2(CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M_IN-1:0]        req,
    input  logic [M_IN*FLIT_W-1:0] in_flit,
    input  logic                   credit_in,
    output logic [M_IN-1:0]        grant,
    output logic [FLIT_W-1:0]      out_flit,
    output logic                   out_valid,
    output logic [CW-1:0]          credit_cnt,
    output logic                   locked,
    output logic                   credit_err
);

    localparam int PW = (M_IN > 1) ? $clog2(M_IN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     r_lock_port;
    logic [PW-1:0]     w_lock_port_nxt;
    logic [CW-1:0]     r_credit_cnt;
    logic [CW-1:0]     w_credit_nxt;
    logic              r_credit_err;
    logic              w_credit_err_nxt;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;

    logic [PW:0]       w_sum;
    logic              w_found;
    logic [PW-1:0]     w_win;
    logic              w_grant_any;
    logic [PW-1:0]     w_gport;
    logic [PW-1:0]     w_ptr_inc;
    logic [FLIT_W-1:0] w_sel_flit;
    logic              w_tail;

    // Rotating search: first requesting port at or above ptr, wrapping past M_IN-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int off = 0; off < M_IN; off++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(off);
            w_sum = (w_sum >= (PW+1)'(M_IN)) ? (w_sum - (PW+1)'(M_IN)) : w_sum;
            if (!w_found && req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant decision: needs a credit; a held lock restricts the choice to the locked port.
    always_comb begin
        w_grant_any = 1'b0;
        w_gport     = '0;
        if (rst && (r_credit_cnt != '0)) begin
            case (r_state)
                ST_IDLE: begin
                    w_grant_any = w_found;
                    w_gport     = w_win;
                end
                ST_LOCKED: begin
                    w_grant_any = req[r_lock_port];
                    w_gport     = r_lock_port;
                end
                default: begin
                    w_grant_any = 1'b0;
                    w_gport     = '0;
                end
            endcase
        end else begin
            w_grant_any = 1'b0;
        end
    end

    assign grant      = w_grant_any ? ({{(M_IN-1){1'b0}}, 1'b1} << w_gport) : '0;
    assign w_sel_flit = in_flit[int'(w_gport)*FLIT_W +: FLIT_W];
    assign w_tail     = w_sel_flit[TAIL_POS];
    assign w_ptr_inc  = (w_gport == PW'(M_IN - 1)) ? '0 : (w_gport + PW'(1));

    // Next state, pointer and lock owner; ptr stays frozen while a packet is in flight.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_lock_port_nxt = r_lock_port;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (!w_tail) begin
                        w_state_nxt     = ST_LOCKED;
                        w_lock_port_nxt = w_gport;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_grant_any && w_tail) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_ptr_inc;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Credit bookkeeping; a return with the pool already full is flagged instead of counted.
    always_comb begin
        w_credit_nxt     = r_credit_cnt;
        w_credit_err_nxt = r_credit_err;
        if (w_grant_any && !credit_in) begin
            w_credit_nxt = r_credit_cnt - CW'(1);
        end else if (!w_grant_any && credit_in) begin
            if (r_credit_cnt == CW'(CREDITS)) begin
                w_credit_err_nxt = 1'b1;
            end else begin
                w_credit_nxt = r_credit_cnt + CW'(1);
            end
        end else begin
            w_credit_nxt = r_credit_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration pointers, credits and the registered output flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_lock_port  <= '0;
            r_credit_cnt <= CW'(CREDITS);
            r_credit_err <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_flit   <= '0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_lock_port  <= w_lock_port_nxt;
            r_credit_cnt <= w_credit_nxt;
            r_credit_err <= w_credit_err_nxt;
            r_out_valid  <= w_grant_any;
            r_out_flit   <= w_grant_any ? w_sel_flit : r_out_flit;
        end
    end

    assign out_flit   = r_out_flit;
    assign out_valid  = r_out_valid;
    assign credit_cnt = r_credit_cnt;
    assign locked     = (r_state == ST_LOCKED);
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the arbitration rules.
module tb_port_arbiter;

    localparam int M_IN     = 6;
    localparam int FLIT_W   = 85;
    localparam int TAIL_POS = 80;
    localparam int CREDITS  = 4;
    localparam int CW       = $clog2(CREDITS + 1);

    logic                   clk;
    logic                   rst;
    logic [M_IN-1:0]        req;
    logic [M_IN*FLIT_W-1:0] in_flit;
    logic                   credit_in;
    logic [M_IN-1:0]        grant;
    logic [FLIT_W-1:0]      out_flit;
    logic                   out_valid;
    logic [CW-1:0]          credit_cnt;
    logic                   locked;
    logic                   credit_err;

    port_arbiter #(
        .M_IN(M_IN), .FLIT_W(FLIT_W), .TAIL_POS(TAIL_POS), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .in_flit(in_flit), .credit_in(credit_in),
        .grant(grant), .out_flit(out_flit), .out_valid(out_valid),
        .credit_cnt(credit_cnt), .locked(locked), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int                m_ptr;
    int                m_lport;
    int                m_cred;
    bit                m_locked;
    bit                m_err;
    bit                m_ov;
    logic [FLIT_W-1:0] m_of;

    typedef struct {
        logic [M_IN-1:0] req;
        logic [M_IN-1:0] tail;
        logic            cin;
        logic [M_IN-1:0] exp_g;
        int              exp_cred;
        logic            exp_lock;
    } vec_t;

    vec_t tbl[25];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input logic [M_IN-1:0] v, input int i);
        logic [M_IN-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [FLIT_W-1:0] flit_at(input int i);
        logic [M_IN*FLIT_W-1:0] t;
        t = in_flit >> (i * FLIT_W);
        return t[FLIT_W-1:0];
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_lport  = 0;
        m_cred   = CREDITS;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_ov     = 1'b0;
        m_of     = '0;
    endtask

    task automatic model_grant(output logic [M_IN-1:0] g, output int k);
        logic [M_IN-1:0] one;
        one = 1;
        k   = -1;
        if (m_cred > 0) begin
            if (m_locked) begin
                if (bit_at(req, m_lport)) k = m_lport;
            end else begin
                for (int o = 0; o < M_IN; o++) begin
                    int p;
                    p = (m_ptr + o) % M_IN;
                    if (k < 0 && bit_at(req, p)) k = p;
                end
            end
        end
        g = (k >= 0) ? (one << k) : '0;
    endtask

    task automatic model_update(input int k, input logic c);
        logic [FLIT_W-1:0] f;
        if (k >= 0) begin
            f    = flit_at(k);
            m_ov = 1'b1;
            m_of = f;
            if (!m_locked) begin
                m_ptr = (k + 1) % M_IN;
                if (!f[TAIL_POS]) begin
                    m_locked = 1'b1;
                    m_lport  = k;
                end
            end else if (f[TAIL_POS]) begin
                m_locked = 1'b0;
                m_ptr    = (m_lport + 1) % M_IN;
            end
        end else begin
            m_ov = 1'b0;
        end
        if (k >= 0 && !c) m_cred = m_cred - 1;
        else if (k < 0 && c) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else m_cred = m_cred + 1;
        end
    endtask

    // One clock cycle: drive inputs, compare at mid-cycle, then advance past the edge.
    task automatic step(input logic [M_IN-1:0] r, input logic [M_IN-1:0] t, input logic c,
                        input logic chk_tbl, input logic [M_IN-1:0] eg, input int ec,
                        input logic el);
        logic [95:0]       rnd;
        logic [FLIT_W-1:0] f;
        logic [M_IN-1:0]   g;
        int                k;
        req       = r;
        credit_in = c;
        for (int i = 0; i < M_IN; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            f   = rnd[FLIT_W-1:0];
            f[TAIL_POS] = bit_at(t, i);
            in_flit[i*FLIT_W +: FLIT_W] = f;
        end
        #3;
        model_grant(g, k);
        check("grant", 128'(grant), 128'(g));
        check("locked", 128'(locked), 128'(m_locked));
        check("credit_cnt", 128'(credit_cnt), 128'(m_cred));
        check("credit_err", 128'(credit_err), 128'(m_err));
        check("out_valid", 128'(out_valid), 128'(m_ov));
        check("out_flit", 128'(out_flit), 128'(m_of));
        if (chk_tbl) begin
            check("tbl_grant", 128'(grant), 128'(eg));
            check("tbl_credit", 128'(credit_cnt), 128'(ec));
            check("tbl_locked", 128'(locked), 128'(el));
        end
        @(posedge clk);
        #1;
        model_update(k, c);
    endtask

    task automatic pulse_reset();
        req       = '0;
        credit_in = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]     a;
        logic [31:0]     b;
        logic [M_IN-1:0] one;
        one = 1;

        // Table: credit exhaustion, concurrent grant+credit, overflow, packet lock, pointer wrap.
        tbl[0]  = '{6'b100001, 6'b111111, 1'b0, 6'b000001, 4, 1'b0};
        tbl[1]  = '{6'b100001, 6'b111111, 1'b0, 6'b100000, 3, 1'b0};
        tbl[2]  = '{6'b100001, 6'b111111, 1'b0, 6'b000001, 2, 1'b0};
        tbl[3]  = '{6'b100001, 6'b111111, 1'b0, 6'b100000, 1, 1'b0};
        tbl[4]  = '{6'b100001, 6'b111111, 1'b0, 6'b000000, 0, 1'b0};
        tbl[5]  = '{6'b100001, 6'b111111, 1'b0, 6'b000000, 0, 1'b0};
        tbl[6]  = '{6'b100001, 6'b111111, 1'b1, 6'b000000, 0, 1'b0};
        tbl[7]  = '{6'b100001, 6'b111111, 1'b0, 6'b000001, 1, 1'b0};
        tbl[8]  = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 0, 1'b0};
        tbl[9]  = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 1, 1'b0};
        tbl[10] = '{6'b000010, 6'b111111, 1'b1, 6'b000010, 2, 1'b0};
        tbl[11] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 2, 1'b0};
        tbl[12] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 3, 1'b0};
        tbl[13] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 4, 1'b0};
        tbl[14] = '{6'b010100, 6'b000000, 1'b0, 6'b000100, 4, 1'b0};
        tbl[15] = '{6'b010100, 6'b000000, 1'b0, 6'b000100, 3, 1'b1};
        tbl[16] = '{6'b010100, 6'b000100, 1'b0, 6'b000100, 2, 1'b1};
        tbl[17] = '{6'b010000, 6'b111111, 1'b1, 6'b010000, 1, 1'b0};
        tbl[18] = '{6'b100000, 6'b111111, 1'b0, 6'b100000, 1, 1'b0};
        tbl[19] = '{6'b111111, 6'b111111, 1'b1, 6'b000000, 0, 1'b0};
        tbl[20] = '{6'b111111, 6'b111111, 1'b0, 6'b000001, 1, 1'b0};
        tbl[21] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 0, 1'b0};
        tbl[22] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 1, 1'b0};
        tbl[23] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 2, 1'b0};
        tbl[24] = '{6'b000000, 6'b111111, 1'b1, 6'b000000, 3, 1'b0};

        rst       = 1'b0;
        req       = '1;
        in_flit   = '0;
        credit_in = 1'b0;
        model_reset();

        // Reset values, with every port requesting while reset is held
        #12;
        check("rst_grant", 128'(grant), 128'(0));
        check("rst_locked", 128'(locked), 128'(0));
        check("rst_credit", 128'(credit_cnt), 128'(CREDITS));
        check("rst_err", 128'(credit_err), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_flit", 128'(out_flit), 128'(0));
        req = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++)
            step(tbl[i].req, tbl[i].tail, tbl[i].cin, 1'b1, tbl[i].exp_g, tbl[i].exp_cred,
                 tbl[i].exp_lock);
        check("err_sticky", 128'(credit_err), 128'(1));

        // All ports requesting, credit returned every cycle after the first
        pulse_reset();
        for (int i = 0; i < 7; i++)
            step(6'b111111, 6'b111111, (i > 0), 1'b1, one << (i % M_IN), (i == 0) ? 4 : 3, 1'b0);

        // Asynchronous reset while a packet holds the output with one credit left
        step(6'b000010, 6'b000000, 1'b0, 1'b1, 6'b000010, 3, 1'b0);
        step(6'b000010, 6'b000000, 1'b0, 1'b1, 6'b000010, 2, 1'b1);
        #2;
        check("pre_rst_locked", 128'(locked), 128'(1));
        check("pre_rst_credit", 128'(credit_cnt), 128'(1));
        check("pre_rst_grant", 128'(grant), 128'(6'b000010));
        rst = 1'b0;
        #1;
        check("async_locked", 128'(locked), 128'(0));
        check("async_valid", 128'(out_valid), 128'(0));
        check("async_grant", 128'(grant), 128'(0));
        check("async_credit", 128'(credit_cnt), 128'(CREDITS));
        req = '0;
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(6'b100100, 6'b111111, 1'b0, 1'b1, 6'b000100, 4, 1'b0);

        // Random traffic: mostly single-flit packets, mixed credit returns
        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            b = $urandom | $urandom;
            step(a[M_IN-1:0], b[M_IN-1:0], ($urandom_range(0, 99) < 45), 1'b0, '0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 The module SHALL have parameter M_IN, default 6, giving the number of requesting input ports.
REQ-002 The module SHALL have parameter FLIT_W, default 85, giving the flit-plus-children width (ValidBitPos 81 + 1 + lg_numprocs 3).
REQ-003 The module SHALL have parameter TAIL_POS, default 80, giving the flit bit that marks the last flit of a packet.
REQ-004 The module SHALL have parameter CREDITS, default 4, giving the downstream buffer depth; CW = clog2(CREDITS+1).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 req  input  M_IN  per-port request; bit i = port i holds a flit routed to this output.
REQ-008 in_flit  input  M_IN*FLIT_W  flits; port i occupies bits [i*FLIT_W +: FLIT_W].
REQ-009 credit_in  input  1  one-cycle pulse; downstream has freed one buffer slot.
REQ-010 grant  output  M_IN  combinational one-hot pop to the winning input port; all zero when no grant.
REQ-011 out_flit  output  FLIT_W  registered copy of the granted flit.
REQ-012 out_valid  output  1  registered; 1 for exactly one cycle per granted flit.
REQ-013 credit_cnt  output  CW  current available credits.
REQ-014 locked  output  1  1 while a multi-flit packet holds the output (state LOCKED).
REQ-015 credit_err  output  1  sticky; credit return received while credit_cnt == CREDITS.

Function
REQ-016 Grant eligibility SHALL require credit_cnt > 0; with 0 credits grant SHALL be all zero regardless of req.
REQ-017 At most one grant bit SHALL be set per cycle.
REQ-018 In state IDLE, the winner SHALL be the first set req bit searching from ptr upward, modulo M_IN (index M_IN-1 wraps to 0).
REQ-019 After a grant to port k, ptr SHALL become (k+1) mod M_IN on the next edge; with no grant, ptr SHALL be unchanged.
REQ-020 Latency SHALL be one cycle: a grant in cycle N SHALL produce out_valid=1 with out_flit = in_flit[k] in cycle N+1.
REQ-021 With no grant in cycle N, out_valid SHALL be 0 in cycle N+1 and out_flit SHALL hold its previous value.
REQ-022 The FSM SHALL have two states. IDLE -> LOCKED on a grant whose flit has bit TAIL_POS = 0; lock_port = k.
REQ-023 In LOCKED, only req[lock_port] SHALL be considered; other requests SHALL be ignored and ptr SHALL be frozen.
REQ-024 LOCKED -> IDLE on a grant whose flit has TAIL_POS = 1; ptr SHALL then become (lock_port+1) mod M_IN.
REQ-025 In LOCKED, if req[lock_port]=0 or credits are 0, the FSM SHALL stay LOCKED with no grant.
REQ-026 The credit counter SHALL decrement by 1 on a grant cycle and increment by 1 on a credit_in cycle.
REQ-027 If a grant and credit_in occur in the same cycle, credit_cnt SHALL be unchanged.
REQ-028 If credit_in arrives at credit_cnt == CREDITS with no same-cycle grant, credit_cnt SHALL stay at CREDITS and credit_err SHALL set.
REQ-029 credit_cnt SHALL never underflow; this is guaranteed by REQ-016.

Reset
REQ-030 While rst=0, the block SHALL asynchronously force: state IDLE, ptr 0, lock_port 0, credit_cnt CREDITS, out_valid 0, out_flit 0, credit_err 0, locked 0.
REQ-031 While rst=0, grant SHALL be 0.
REQ-032 Reset mid-packet SHALL abandon the lock; after rst returns to 1, the first grant SHALL follow IDLE rules from ptr 0.

Verification
REQ-033 Scenario 1: req=6'b111111 held, all flits tail=1, credit_in pulsed every cycle from cycle 1 -> grants to ports 0,1,2,3,4,5,0 on successive cycles; credit_cnt holds 3 after the first grant.
REQ-034 Scenario 2: after reset, req=6'b100001 with no credit_in -> 4 grants (0,5,0,5); credit_cnt reaches 0; grant stays 0 until credit_in.
REQ-035 Scenario 3: port 2 sends 3 flits (tail=0,0,1) while req[4]=1 -> locked=1 for 2 cycles; port 4 is granted only after port 2's tail; ptr = 3 at that point.
REQ-036 Scenario 4: grant and credit_in in the same cycle at credit_cnt=2 -> credit_cnt stays 2; a lone credit_in at 4 -> credit_cnt stays 4 and credit_err = 1 until reset.
REQ-037 Scenario 5: rst=0 asserted asynchronously mid-cycle in LOCKED with credit_cnt=1 -> locked, out_valid and grant drop immediately; credit_cnt reads 4.
REQ-038 Scenario 6: req=6'b100000 with ptr=5 after a grant to port 4 -> port 5 is granted; ptr wraps to 0.
